// File: rtl/preempt_scheduler.sv
// Round-robin preemption source for a 4-context processor: counts a quantum on
// Slow_Clock and requests a switch to the next runnable context until acknowledged.
module preempt_scheduler #(
  parameter int unsigned QUANTUM_W   = 16,
  parameter int unsigned QUANTUM_DEF = 1000,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                 Slow_Clock,
  input  logic                 Raw_Reset_I,
  input  logic                 Sched_Enable,
  input  logic [3:0]           Proc_Active,
  input  logic [1:0]           Proc_ID,
  input  logic                 Change_Context,
  input  logic                 Quantum_Load,
  input  logic [QUANTUM_W-1:0] Quantum_In,
  output logic                 Sched_Req,
  output logic [1:0]           Sched_Proc_ID,
  output logic [QUANTUM_W-1:0] Quantum_Left,
  output logic                 Sched_Idle,
  output logic                 Sched_Err
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [QUANTUM_W-1:0] QDEF = QUANTUM_W'(QUANTUM_DEF);
  localparam logic [QUANTUM_W-1:0] QONE = QUANTUM_W'(1);

  typedef enum logic {COUNT, REQ} state_t;

  state_t               state;
  logic [QUANTUM_W-1:0] quantum;
  logic [QUANTUM_W-1:0] load_val;
  logic [QUANTUM_W-1:0] reload_val;
  logic [TW-1:0]        ack_timer;
  logic                 next_found;
  logic [1:0]           next_id;

  assign Sched_Idle = (Proc_Active == '0);
  assign load_val   = (Quantum_In == '0) ? QONE : Quantum_In;
  // A load arriving on the exit cycle of REQ is already the quantum used for the reload.
  assign reload_val = Quantum_Load ? load_val : quantum;

  // Search Proc_ID+1, +2, +3 (mod 4); the running context is never a candidate.
  always_comb begin
    next_found = 1'b0;
    next_id    = Proc_ID;
    for (int unsigned k = 1; k < 4; k++) begin
      if (!next_found && Proc_Active[Proc_ID + 2'(k)]) begin
        next_found = 1'b1;
        next_id    = Proc_ID + 2'(k);
      end
    end
  end

  always_ff @(posedge Slow_Clock) begin
    if (!Raw_Reset_I) begin
      state         <= COUNT;
      quantum       <= QDEF;
      Quantum_Left  <= QDEF;
      Sched_Req     <= 1'b0;
      Sched_Proc_ID <= '0;
      Sched_Err     <= 1'b0;
      ack_timer     <= '0;
    end else begin
      if (Quantum_Load) quantum <= load_val;
      case (state)
        COUNT: begin
          if (Quantum_Load) begin
            Quantum_Left <= load_val;
          end else if (Change_Context) begin
            Quantum_Left <= quantum;
          end else if (Sched_Enable && !Sched_Idle) begin
            if (Quantum_Left == QONE) begin
              if (next_found) begin
                state         <= REQ;
                Sched_Req     <= 1'b1;
                Sched_Proc_ID <= next_id;
                ack_timer     <= '0;
                Quantum_Left  <= '0;
              end else begin
                Quantum_Left <= quantum;
              end
            end else begin
              Quantum_Left <= Quantum_Left - QONE;
            end
          end
        end
        REQ: begin
          // Ack outranks both withdrawal and timeout.
          if (Change_Context || !Proc_Active[Sched_Proc_ID] || !Sched_Enable) begin
            state        <= COUNT;
            Sched_Req    <= 1'b0;
            Quantum_Left <= reload_val;
          end else if (ack_timer == TIMER_LAST) begin
            state        <= COUNT;
            Sched_Req    <= 1'b0;
            Sched_Err    <= 1'b1;
            Quantum_Left <= reload_val;
          end else begin
            ack_timer <= ack_timer + TW'(1);
          end
        end
        default: state <= COUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_preempt_scheduler.sv
// Bench for preempt_scheduler: directed scenarios plus randomized traffic against a
// behavioural model of the quantum/request rules.
module tb_preempt_scheduler;

  localparam int QW   = 16;
  localparam int QDEF = 1000;
  localparam int TO   = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [3:0]    act = '0;
  logic [1:0]    pid = '0;
  logic          cc = 1'b0;
  logic          ql = 1'b0;
  logic [QW-1:0] qin = '0;
  logic          req;
  logic [1:0]    req_id;
  logic [QW-1:0] left;
  logic          idle;
  logic          err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // reference model state
  bit m_req;
  int m_id;
  int m_left;
  int m_q;
  bit m_err;
  int m_waited;

  preempt_scheduler #(
    .QUANTUM_W  (QW),
    .QUANTUM_DEF(QDEF),
    .ACK_TIMEOUT(TO)
  ) dut (
    .Slow_Clock    (clk),
    .Raw_Reset_I   (rst_n),
    .Sched_Enable  (en),
    .Proc_Active   (act),
    .Proc_ID       (pid),
    .Change_Context(cc),
    .Quantum_Load  (ql),
    .Quantum_In    (qin),
    .Sched_Req     (req),
    .Sched_Proc_ID (req_id),
    .Quantum_Left  (left),
    .Sched_Idle    (idle),
    .Sched_Err     (err)
  );

  always #5 clk = ~clk;

  // One clock edge of the specified behaviour, using inputs as seen at the edge.
  task automatic model_edge();
    int ldv;
    int nxt;
    ldv = (qin == 0) ? 1 : int'(qin);
    if (!rst_n) begin
      m_req = 0; m_id = 0; m_left = QDEF; m_q = QDEF; m_err = 0; m_waited = 0;
    end else if (!m_req) begin
      if (ql) m_left = ldv;
      else if (cc) m_left = m_q;
      else if (en && act != 0) begin
        if (m_left == 1) begin
          nxt = -1;
          for (int k = 3; k >= 1; k--)
            if (act[(int'(pid) + k) % 4]) nxt = (int'(pid) + k) % 4;
          if (nxt >= 0) begin
            m_req = 1; m_id = nxt; m_left = 0; m_waited = 0;
          end else begin
            m_left = m_q;
          end
        end else begin
          m_left = m_left - 1;
        end
      end
      if (ql) m_q = ldv;
    end else begin
      if (ql) m_q = ldv;
      m_waited = m_waited + 1;
      if (cc || !act[m_id] || !en) begin
        m_req = 0; m_left = m_q;
      end else if (m_waited >= TO) begin
        m_req = 0; m_left = m_q; m_err = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [20:0] observed();
    return {req, req_id, left, idle, err};
  endfunction

  function automatic logic [20:0] expected();
    return {m_req, 2'(m_id), QW'(m_left), (act == 4'b0000), m_err};
  endfunction

  task automatic test_reset();
    rst_n = 0; en = 1; act = 4'b0000; pid = 0; cc = 0; ql = 0; qin = 0;
    step();
    tests++;
    if ({req, req_id, left, err} !== {1'b0, 2'd0, 16'(QDEF), 1'b0} || idle !== 1'b1) begin
      fails++;
      $display("FAIL reset: got req=%b id=%0d left=%0d idle=%b err=%b, expected 0 0 %0d 1 0",
               req, req_id, left, idle, err, QDEF);
    end
    rst_n = 1;
  endtask

  task automatic test_basic();
    act = 4'b1111; pid = 0; en = 1; ql = 1; qin = 5;
    step();
    ql = 0;
    tests++;
    if (left !== 16'd5 || idle !== 1'b0) begin
      fails++; $display("FAIL basic_load: left=%0d idle=%b, expected 5 0", left, idle);
    end
    repeat (4) begin
      step();
      tests++;
      if (req !== 1'b0 || observed() !== expected()) begin
        fails++; $display("FAIL basic_count cyc %0d: got %h expected %h (req 0)", cyc, observed(), expected());
      end
    end
    step();
    tests++;
    if (req !== 1'b1 || req_id !== 2'd1 || left !== '0) begin
      fails++; $display("FAIL basic_req: req=%b id=%0d left=%0d, expected 1 1 0", req, req_id, left);
    end
    repeat (2) step();
    cc = 1;
    step();
    cc = 0;
    tests++;
    if (req !== 1'b0 || left !== 16'd5) begin
      fails++; $display("FAIL basic_ack: req=%b left=%0d, expected 0 5", req, left);
    end
  endtask

  task automatic test_wrap();
    act = 4'b1001; pid = 3; ql = 1; qin = 3;
    step();
    ql = 0;
    repeat (3) step();
    tests++;
    if (req !== 1'b1 || req_id !== 2'd0) begin
      fails++; $display("FAIL wrap_select: req=%b id=%0d, expected 1 0", req, req_id);
    end
    cc = 1;
    step();
    cc = 0;
    act = 4'b1000;
    repeat (3) step();
    tests++;
    if (req !== 1'b0 || left !== 16'd3) begin
      fails++; $display("FAIL wrap_none: req=%b left=%0d, expected 0 3", req, left);
    end
  endtask

  task automatic test_timeout();
    act = 4'b1111; pid = 0; ql = 1; qin = 2;
    step();
    ql = 0;
    repeat (2) step();
    for (int i = 0; i < TO - 1; i++) begin
      step();
      tests++;
      if (req !== 1'b1 || err !== 1'b0 || observed() !== expected()) begin
        fails++; $display("FAIL timeout_wait %0d: req=%b err=%b, expected 1 0", i, req, err);
      end
    end
    step();
    tests++;
    if (req !== 1'b0 || err !== 1'b1 || left !== 16'd2) begin
      fails++; $display("FAIL timeout_fire: req=%b err=%b left=%0d, expected 0 1 2", req, err, left);
    end
    repeat (2) step();
    cc = 1;
    step();
    cc = 0;
    tests++;
    if (req !== 1'b0 || err !== 1'b1) begin
      fails++; $display("FAIL timeout_sticky: req=%b err=%b, expected 0 1", req, err);
    end
    rst_n = 0;
    step();
    rst_n = 1;
    tests++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL timeout_clear: err=%b, expected 0", err);
    end
  endtask

  task automatic test_withdraw();
    act = 4'b1111; pid = 1; ql = 1; qin = 2;
    step();
    ql = 0;
    repeat (2) step();
    tests++;
    if (req !== 1'b1 || req_id !== 2'd2) begin
      fails++; $display("FAIL withdraw_req: req=%b id=%0d, expected 1 2", req, req_id);
    end
    act = 4'b1011;
    step();
    tests++;
    if (req !== 1'b0 || err !== 1'b0 || left !== 16'd2) begin
      fails++; $display("FAIL withdraw_drop: req=%b err=%b left=%0d, expected 0 0 2", req, err, left);
    end
    act = 4'b1111;
  endtask

  task automatic test_load_zero();
    pid = 1; ql = 1; qin = 0;
    step();
    ql = 0;
    tests++;
    if (left !== 16'd1 || req !== 1'b0) begin
      fails++; $display("FAIL zero_load: left=%0d req=%b, expected 1 0", left, req);
    end
    step();
    tests++;
    if (req !== 1'b1 || req_id !== 2'd2) begin
      fails++; $display("FAIL zero_req: req=%b id=%0d, expected 1 2", req, req_id);
    end
    ql = 1; qin = 7;
    step();
    ql = 0;
    tests++;
    if (req !== 1'b1 || left !== '0) begin
      fails++; $display("FAIL req_load_hold: req=%b left=%0d, expected 1 0", req, left);
    end
    cc = 1;
    step();
    cc = 0;
    tests++;
    if (req !== 1'b0 || left !== 16'd7) begin
      fails++; $display("FAIL req_load_reload: req=%b left=%0d, expected 0 7", req, left);
    end
  endtask

  task automatic test_reset_mid();
    ql = 1; qin = 1;
    step();
    ql = 0;
    step();
    tests++;
    if (req !== 1'b1) begin
      fails++; $display("FAIL resetmid_req: req=%b, expected 1", req);
    end
    rst_n = 0; cc = 1;
    step();
    rst_n = 1; cc = 0;
    tests++;
    if (req !== 1'b0 || left !== 16'(QDEF) || req_id !== 2'd0) begin
      fails++; $display("FAIL resetmid: req=%b left=%0d id=%0d, expected 0 %0d 0", req, left, req_id, QDEF);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(199) != 0);
      en    = ($urandom_range(9) != 0);
      act   = ($urandom_range(7) == 0) ? 4'b0000 : 4'($urandom);
      pid   = 2'($urandom);
      cc    = ($urandom_range(9) == 0);
      ql    = ($urandom_range(24) == 0);
      qin   = QW'($urandom_range(6));
      step();
      tests++;
      if (observed() !== expected()) begin
        fails++;
        $display("FAIL random cyc %0d: got req/id/left/idle/err=%h expected %h", cyc, observed(), expected());
      end
    end
    rst_n = 1; cc = 0; ql = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_timeout();
    test_withdraw();
    test_load_zero();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
